// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the control unit / iterative units and the
// multiply-divide sequencer. The master side is the control unit plus the two units;
// the slave side is the sequencer itself.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   // Request handshake from the control unit
   logic             Op_Start;
   logic             Op_Sel;
   logic             Op_Ready;
   logic             Busy;

   // Iterative unit control and results
   logic             Mult_Go;
   logic             Div_Go;
   logic             Mult_Done;
   logic             Div_Done;
   logic             Div_Zero_In;
   logic [WIDTH-1:0] Mult_HI;
   logic [WIDTH-1:0] Mult_LO;
   logic [WIDTH-1:0] Div_HI;
   logic [WIDTH-1:0] Div_LO;

   // Architectural HI/LO access and exception reporting
   logic             Hilo_Read;
   logic             Stall;
   logic [WIDTH-1:0] HI_Out;
   logic [WIDTH-1:0] LO_Out;
   logic             Div_Zero_Exc;
   logic             Timeout_Err;

   modport master (
      output Op_Start, Op_Sel, Mult_Done, Div_Done, Div_Zero_In,
             Mult_HI, Mult_LO, Div_HI, Div_LO, Hilo_Read,
      input  Op_Ready, Busy, Mult_Go, Div_Go, Stall, HI_Out, LO_Out,
             Div_Zero_Exc, Timeout_Err
   );

   modport slave (
      input  Op_Start, Op_Sel, Mult_Done, Div_Done, Div_Zero_In,
             Mult_HI, Mult_LO, Div_HI, Div_LO, Hilo_Read,
      output Op_Ready, Busy, Mult_Go, Div_Go, Stall, HI_Out, LO_Out,
             Div_Zero_Exc, Timeout_Err
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer: accepts one MULT/DIV request, holds the selected unit's
// Go until it finishes, commits HI/LO, flags divide-by-zero and watchdog expiry, and
// stalls MFHI/MFLO while an operation is in flight.
module muldiv_sequencer #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 40,
   parameter int DRAIN_CYCLES   = 1
) (
   input logic               Clock,
   input logic               Reset,
   muldiv_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   state_t           state, state_nx;
   logic             op_div, op_div_nx;
   logic [7:0]       cnt, cnt_nx;
   logic [3:0]       drain_cnt, drain_cnt_nx;
   logic [WIDTH-1:0] hi_q, hi_nx;
   logic [WIDTH-1:0] lo_q, lo_nx;
   logic             dz_q, dz_nx;
   logic             to_q, to_nx;
   logic             mult_go_q, div_go_q;
   logic             sel_done;

   // Next-state, counter and HI/LO commit decisions for the IDLE -> RUN -> DRAIN cycle.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_nx     = state;
      op_div_nx    = op_div;
      cnt_nx       = cnt;
      drain_cnt_nx = drain_cnt;
      hi_nx        = hi_q;
      lo_nx        = lo_q;
      dz_nx        = 1'b0;
      to_nx        = 1'b0;
      sel_done     = op_div ? bus.Div_Done : bus.Mult_Done;

      case (state)
         S_IDLE: begin
            if (bus.Op_Start) begin
               op_div_nx = bus.Op_Sel;
               cnt_nx    = '0;
               state_nx  = S_RUN;
            end
         end
         S_RUN: begin
            if (op_div && bus.Div_Zero_In) begin
               dz_nx        = 1'b1;
               drain_cnt_nx = '0;
               state_nx     = S_DRAIN;
            end else if (sel_done) begin
               hi_nx        = op_div ? bus.Div_HI : bus.Mult_HI;
               lo_nx        = op_div ? bus.Div_LO : bus.Mult_LO;
               drain_cnt_nx = '0;
               state_nx     = S_DRAIN;
            end else if (cnt == TO_LAST) begin
               to_nx        = 1'b1;
               drain_cnt_nx = '0;
               state_nx     = S_DRAIN;
            end else if (cnt != 8'hFF) begin
               cnt_nx = cnt + 8'd1;
            end
         end
         S_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
               state_nx = S_IDLE;
            end else begin
               drain_cnt_nx = drain_cnt + 4'd1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State, counters, HI/LO, pulses and registered Go outputs; synchronous reset aborts any op.
   always_ff @(posedge Clock) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (Reset) begin
         state     <= S_IDLE;
         op_div    <= 1'b0;
         cnt       <= '0;
         drain_cnt <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dz_q      <= 1'b0;
         to_q      <= 1'b0;
         mult_go_q <= 1'b0;
         div_go_q  <= 1'b0;
      end else begin
         state     <= state_nx;
         op_div    <= op_div_nx;
         cnt       <= cnt_nx;
         drain_cnt <= drain_cnt_nx;
         hi_q      <= hi_nx;
         lo_q      <= lo_nx;
         dz_q      <= dz_nx;
         to_q      <= to_nx;
         mult_go_q <= (state_nx == S_RUN) && !op_div_nx;
         div_go_q  <= (state_nx == S_RUN) &&  op_div_nx;
      end
   end

   assign bus.Op_Ready     = (state == S_IDLE);
   assign bus.Busy         = (state == S_RUN) || (state == S_DRAIN);
   assign bus.Stall        = bus.Hilo_Read && bus.Busy;
   assign bus.Mult_Go      = mult_go_q;
   assign bus.Div_Go       = div_go_q;
   assign bus.HI_Out       = hi_q;
   assign bus.LO_Out       = lo_q;
   assign bus.Div_Zero_Exc = dz_q;
   assign bus.Timeout_Err  = to_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus randomized
// operations, each predicted by an outcome model (first event wins, by priority).
module tb_muldiv_sequencer;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 40;

   localparam int K_DONE    = 0;
   localparam int K_ZERO    = 1;
   localparam int K_TIMEOUT = 2;

   logic Clock;
   logic Reset;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [WIDTH-1:0] exp_hi = '0;
   logic [WIDTH-1:0] exp_lo = '0;

   muldiv_sequencer_if #(.WIDTH(WIDTH)) bus_if ();

   muldiv_sequencer #(
      .WIDTH         (WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT),
      .DRAIN_CYCLES  (1)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus_if)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus_if.Op_Start    = 1'b0;
      bus_if.Op_Sel      = 1'b0;
      bus_if.Mult_Done   = 1'b0;
      bus_if.Div_Done    = 1'b0;
      bus_if.Div_Zero_In = 1'b0;
      bus_if.Mult_HI     = '0;
      bus_if.Mult_LO     = '0;
      bus_if.Div_HI      = '0;
      bus_if.Div_LO      = '0;
      bus_if.Hilo_Read   = 1'b0;
   endtask

   // One complete operation. done_at / zero_at are 1-based RUN cycles (0 = never).
   task automatic run_op(input logic sel, input int done_at, input int zero_at,
                         input logic [31:0] hi_v, input logic [31:0] lo_v,
                         input logic rd, input logic poke);
      int   first;
      int   kind;
      int   go_cnt;
      logic go;
      logic other_go;

      // Outcome model: earliest event within the watchdog window; zero beats done, done beats timeout.
      first = TIMEOUT;
      kind  = K_TIMEOUT;
      if (done_at >= 1 && done_at <= first) begin
         first = done_at;
         kind  = K_DONE;
      end
      if (sel && zero_at >= 1 && zero_at <= first) begin
         first = zero_at;
         kind  = K_ZERO;
      end

      check("idle_ready", bus_if.Op_Ready, 1'b1);
      bus_if.Op_Start  = 1'b1;
      bus_if.Op_Sel    = sel;
      bus_if.Hilo_Read = rd;
      tick();
      bus_if.Op_Start = 1'b0;

      go_cnt = 0;
      for (int c = 1; c <= 60; c++) begin
         go       = sel ? bus_if.Div_Go  : bus_if.Mult_Go;
         other_go = sel ? bus_if.Mult_Go : bus_if.Div_Go;
         if (!go) break;
         go_cnt++;
         if (c == 1) begin
            check("run_other_go", other_go, 1'b0);
            check("run_busy", bus_if.Busy, 1'b1);
            check("run_ready", bus_if.Op_Ready, 1'b0);
         end
         check("run_stall", bus_if.Stall, rd);
         // Selected unit: its Done fires only at done_at; the idle unit is pure noise.
         if (sel) begin
            bus_if.Div_Done    = (c == done_at);
            bus_if.Div_Zero_In = (c == zero_at);
            bus_if.Div_HI      = (c == done_at) ? hi_v : $urandom;
            bus_if.Div_LO      = (c == done_at) ? lo_v : $urandom;
            bus_if.Mult_Done   = 1'($urandom_range(0, 1));
            bus_if.Mult_HI     = $urandom;
            bus_if.Mult_LO     = $urandom;
         end else begin
            bus_if.Mult_Done   = (c == done_at);
            bus_if.Mult_HI     = (c == done_at) ? hi_v : $urandom;
            bus_if.Mult_LO     = (c == done_at) ? lo_v : $urandom;
            bus_if.Div_Done    = 1'($urandom_range(0, 1));
            bus_if.Div_Zero_In = 1'($urandom_range(0, 1));
            bus_if.Div_HI      = $urandom;
            bus_if.Div_LO      = $urandom;
         end
         if (poke) begin
            bus_if.Op_Start = 1'($urandom_range(0, 1));
            bus_if.Op_Sel   = 1'($urandom_range(0, 1));
         end
         tick();
      end

      if (kind == K_DONE) begin
         exp_hi = hi_v;
         exp_lo = lo_v;
      end

      // First DRAIN cycle: outcome visible, Go low, still busy.
      bus_if.Op_Start    = 1'b0;
      bus_if.Div_Zero_In = 1'b0;
      check("run_length", go_cnt, first);
      check("drain_mult_go", bus_if.Mult_Go, 1'b0);
      check("drain_div_go", bus_if.Div_Go, 1'b0);
      check("drain_busy", bus_if.Busy, 1'b1);
      check("drain_ready", bus_if.Op_Ready, 1'b0);
      check("drain_stall", bus_if.Stall, rd);
      check("drain_dz_exc", bus_if.Div_Zero_Exc, kind == K_ZERO);
      check("drain_timeout", bus_if.Timeout_Err, kind == K_TIMEOUT);
      check("drain_hi", bus_if.HI_Out, exp_hi);
      check("drain_lo", bus_if.LO_Out, exp_lo);

      // Done pulses in DRAIN must be ignored.
      bus_if.Mult_Done = 1'b1;
      bus_if.Div_Done  = 1'b1;
      bus_if.Mult_HI   = $urandom;
      bus_if.Mult_LO   = $urandom;
      bus_if.Div_HI    = $urandom;
      bus_if.Div_LO    = $urandom;
      tick();

      check("idle_ready_back", bus_if.Op_Ready, 1'b1);
      check("idle_busy", bus_if.Busy, 1'b0);
      check("idle_stall", bus_if.Stall, 1'b0);
      check("idle_dz_exc", bus_if.Div_Zero_Exc, 1'b0);
      check("idle_timeout", bus_if.Timeout_Err, 1'b0);
      check("idle_hi", bus_if.HI_Out, exp_hi);
      check("idle_lo", bus_if.LO_Out, exp_lo);
      clear_inputs();
   endtask

   initial begin
      int done_at;
      int zero_at;

      clear_inputs();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;

      check("rst_hi", bus_if.HI_Out, 32'd0);
      check("rst_lo", bus_if.LO_Out, 32'd0);
      check("rst_mult_go", bus_if.Mult_Go, 1'b0);
      check("rst_div_go", bus_if.Div_Go, 1'b0);
      check("rst_ready", bus_if.Op_Ready, 1'b1);
      check("rst_busy", bus_if.Busy, 1'b0);
      check("rst_dz_exc", bus_if.Div_Zero_Exc, 1'b0);
      check("rst_timeout", bus_if.Timeout_Err, 1'b0);

      // Done pulse while IDLE is ignored.
      bus_if.Mult_Done = 1'b1;
      bus_if.Mult_LO   = 32'hDEAD;
      tick();
      check("idle_done_ignored_lo", bus_if.LO_Out, 32'd0);
      check("idle_done_no_go", bus_if.Mult_Go, 1'b0);
      clear_inputs();

      run_op(1'b0, 33, 0, 32'd0, 32'd42, 1'b0, 1'b0);           // MULT -> 0:42 after 33 cycles
      run_op(1'b1, 20, 0, 32'd3, 32'd1, 1'b0, 1'b0);            // DIV 8/5 -> rem 3, quot 1
      run_op(1'b1, 0, 2, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0);       // divide by zero in cycle 2
      run_op(1'b0, 0, 0, 32'h1111, 32'h2222, 1'b0, 1'b0);       // watchdog timeout
      run_op(1'b1, 40, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0); // done on final RUN cycle
      run_op(1'b1, 5, 5, 32'h1234, 32'h5678, 1'b0, 1'b0);       // zero beats done
      run_op(1'b0, 41, 0, 32'h9999, 32'h8888, 1'b0, 1'b0);      // done too late -> timeout
      run_op(1'b0, 12, 0, 32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 1'b1); // MFHI stall, Op_Start pokes

      for (int i = 0; i < 20; i++) begin
         done_at = int'($urandom_range(0, 45));
         zero_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 45)) : 0;
         run_op(1'($urandom_range(0, 1)), done_at, zero_at, $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset in RUN cycle 10 with a Done present: abort, no commit.
      check("pre_rst_ready", bus_if.Op_Ready, 1'b1);
      bus_if.Op_Start = 1'b1;
      bus_if.Op_Sel   = 1'b0;
      tick();
      bus_if.Op_Start  = 1'b0;
      bus_if.Hilo_Read = 1'b1;
      for (int c = 1; c < 10; c++) tick();
      check("pre_rst_go", bus_if.Mult_Go, 1'b1);
      bus_if.Mult_Done = 1'b1;
      bus_if.Mult_HI   = 32'h7777;
      bus_if.Mult_LO   = 32'h6666;
      Reset            = 1'b1;
      tick();
      Reset = 1'b0;
      clear_inputs();
      bus_if.Hilo_Read = 1'b1;
      exp_hi = '0;
      exp_lo = '0;
      check("midrst_mult_go", bus_if.Mult_Go, 1'b0);
      check("midrst_div_go", bus_if.Div_Go, 1'b0);
      check("midrst_hi", bus_if.HI_Out, exp_hi);
      check("midrst_lo", bus_if.LO_Out, exp_lo);
      check("midrst_busy", bus_if.Busy, 1'b0);
      check("midrst_stall", bus_if.Stall, 1'b0);
      check("midrst_ready", bus_if.Op_Ready, 1'b1);
      check("midrst_dz_exc", bus_if.Div_Zero_Exc, 1'b0);
      check("midrst_timeout", bus_if.Timeout_Err, 1'b0);
      tick();
      check("midrst_still_idle", bus_if.Mult_Go, 1'b0);
      clear_inputs();

      // Sequencer accepts new work after the abort.
      run_op(1'b1, 7, 0, 32'h0000BEEF, 32'h0000FACE, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
